// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] INST_BYTES = 32'd4;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  // Force a byte address onto a 32-bit instruction word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/perf_counter.sv
// 32-bit wrapping event counter with enable and synchronous clear.
module perf_counter (
  input  logic        clock,
  input  logic        clear,
  input  logic        enable,
  output logic [31:0] count
);

  logic [31:0] count_r;

  // Count enabled events; clear has priority.
  always_ff @(posedge clock) begin
    if (clear) begin
      count_r <= 32'd0;
    end else if (enable) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch-side master for the synchronous instruction ROM: issues word
// addresses, tracks the one-cycle ROM latency and hands words to decode.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 12
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  // ADDR_WIDTH only documents the ROM depth; fetch addressing is full 32-bit.
  if (ADDR_WIDTH < 1) begin : g_addr_width_unused
  end

  fetch_state_e state_r;
  fetch_state_e state_nx_s;
  logic [31:0]  pc_r;
  logic [31:0]  pc_nx_s;
  logic [31:0]  req_pc_r;
  logic [31:0]  req_pc_nx_s;
  logic         req_valid_r;
  logic         req_valid_nx_s;
  logic         misalign_r;
  logic [31:0]  target_s;
  logic         inst_valid_s;
  logic         stall_s;
  logic         accept_s;
  logic [31:0]  rom_addr_s;

  assign target_s     = align_word(redirect_pc);
  assign inst_valid_s = req_valid_r & (state_r == RUN) & ~redirect_valid & ~reset;
  assign stall_s      = inst_valid_s & ~inst_ready;
  assign accept_s     = inst_valid_s & inst_ready;

  // ROM address select; a stall re-reads the presented word so rom_data holds.
  always_comb begin
    rom_addr_s = pc_r;
    if (reset) begin
      rom_addr_s = RESET_PC;
    end else if (redirect_valid) begin
      rom_addr_s = target_s;
    end else if (stall_s) begin
      rom_addr_s = req_pc_r;
    end else begin
      rom_addr_s = pc_r;
    end
  end

  // Next-state and fetch sequencing.
  always_comb begin
    state_nx_s     = state_r;
    pc_nx_s        = pc_r;
    req_pc_nx_s    = req_pc_r;
    req_valid_nx_s = req_valid_r;
    case (state_r)
      RUN: begin
        if (redirect_valid) begin
          req_pc_nx_s    = target_s;
          req_valid_nx_s = 1'b1;
          pc_nx_s        = target_s + INST_BYTES;
        end else if (halt_req) begin
          state_nx_s     = HALT;
          req_valid_nx_s = 1'b0;
        end else if (stall_s) begin
          req_valid_nx_s = req_valid_r;
        end else begin
          req_pc_nx_s    = pc_r;
          req_valid_nx_s = 1'b1;
          pc_nx_s        = pc_r + INST_BYTES;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          state_nx_s     = RUN;
          req_pc_nx_s    = target_s;
          req_valid_nx_s = 1'b1;
          pc_nx_s        = target_s + INST_BYTES;
        end else begin
          state_nx_s     = HALT;
          req_valid_nx_s = 1'b0;
        end
      end
      default: begin
        state_nx_s     = RUN;
        req_valid_nx_s = 1'b0;
      end
    endcase
  end

  // Fetch state registers and the sticky misalignment flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= RUN;
      pc_r        <= RESET_PC;
      req_pc_r    <= RESET_PC;
      req_valid_r <= 1'b0;
      misalign_r  <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      pc_r        <= pc_nx_s;
      req_pc_r    <= req_pc_nx_s;
      req_valid_r <= req_valid_nx_s;
      misalign_r  <= misalign_r | (redirect_valid & (redirect_pc[1:0] != 2'b00));
    end
  end

  perf_counter u_fetch_counter (
    .clock  (clock),
    .clear  (reset),
    .enable (accept_s),
    .count  (fetch_count)
  );

  perf_counter u_stall_counter (
    .clock  (clock),
    .clear  (reset),
    .enable (stall_s),
    .count  (stall_count)
  );

  assign rom_addr     = rom_addr_s;
  assign inst         = rom_data;
  assign pc           = req_pc_r;
  assign inst_valid   = inst_valid_s;
  assign halted       = (state_r == HALT) & ~reset;
  assign misalign_err = misalign_r;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed vector table plus randomized run
// checked against a cycle-level reference model of the fetch rules.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          ADDR_WIDTH = 12;
  localparam int          N_VEC      = 35;
  localparam int          N_RAND     = 3000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  int n_pass  = 0;
  int n_total = 0;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .inst           (inst),
    .pc             (pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
  );

  always #5 clock = ~clock;

  // ROM word k holds k; addresses alias above ADDR_WIDTH word bits.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return w & ((32'd1 << ADDR_WIDTH) - 32'd1);
  endfunction

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clock) rom_data <= rom_word(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    bit rst; bit rdy; bit rv; logic [31:0] rpc; bit hr;
    bit e_valid; logic [31:0] e_pc; logic [31:0] e_inst;
    bit e_halted; bit e_mis; logic [31:0] e_fc; logic [31:0] e_sc;
    bit c_addr; logic [31:0] e_addr;
  } vec_t;

  vec_t tbl [N_VEC];

  function automatic vec_t mk(int rst, int rdy, int rv, logic [31:0] rpc, int hr,
                              int ev, logic [31:0] epc, logic [31:0] einst, int eh, int em,
                              int efc, int esc, int ca, logic [31:0] eaddr);
    vec_t v;
    v.rst = bit'(rst); v.rdy = bit'(rdy); v.rv = bit'(rv); v.rpc = rpc; v.hr = bit'(hr);
    v.e_valid = bit'(ev); v.e_pc = epc; v.e_inst = einst; v.e_halted = bit'(eh);
    v.e_mis = bit'(em); v.e_fc = efc; v.e_sc = esc; v.c_addr = bit'(ca); v.e_addr = eaddr;
    return v;
  endfunction

  // Reference model state: abstract view of what decode should see.
  logic [31:0] m_next, m_pc, m_fc, m_sc;
  bit          m_have, m_halt, m_mis;

  task automatic model_step();
    bit ev;
    ev = !reset && m_have && !m_halt && !redirect_valid;
    if (reset) begin
      m_next = RESET_PC; m_have = 0; m_halt = 0; m_fc = 0; m_sc = 0; m_mis = 0;
    end else begin
      if (ev && inst_ready) m_fc = m_fc + 1;
      if (ev && !inst_ready) m_sc = m_sc + 1;
      if (redirect_valid) begin
        if (redirect_pc % 4 != 0) m_mis = 1;
        m_pc = redirect_pc - (redirect_pc % 4);
        m_next = m_pc + 4;
        m_have = 1;
        m_halt = 0;
      end else if (m_halt) begin
        m_have = 0;
      end else if (halt_req) begin
        m_halt = 1;
        m_have = 0;
      end else if (!(ev && !inst_ready)) begin
        m_pc = m_next;
        m_next = m_next + 4;
        m_have = 1;
      end
    end
  endtask

  task automatic model_check();
    bit          ev;
    logic [31:0] ea;
    ev = !reset && m_have && !m_halt && !redirect_valid;
    check("rnd_valid", {31'd0, inst_valid}, {31'd0, ev});
    if (ev) begin
      check("rnd_pc", pc, m_pc);
      check("rnd_inst", inst, rom_word(m_pc));
    end
    check("rnd_halted", {31'd0, halted}, {31'd0, (!reset && m_halt)});
    check("rnd_misalign", {31'd0, misalign_err}, {31'd0, m_mis});
    check("rnd_fetch_count", fetch_count, m_fc);
    check("rnd_stall_count", stall_count, m_sc);
    if (reset || redirect_valid || !m_halt) begin
      if (reset) ea = RESET_PC;
      else if (redirect_valid) ea = redirect_pc - (redirect_pc % 4);
      else if (ev && !inst_ready) ea = m_pc;
      else ea = m_next;
      check("rnd_rom_addr", rom_addr, ea);
    end
  endtask

  initial begin
    reset = 1; inst_ready = 0; redirect_valid = 0; redirect_pc = 0; halt_req = 0;

    //           rst rdy rv rpc           hr  ev pc            inst   h  m  fc  sc ca addr
    tbl[0]  = mk(1, 1, 0, 0,            0,  0, 0,            0,     0, 0, 0,  0, 1, 0);
    tbl[1]  = mk(0, 1, 0, 0,            0,  0, 0,            0,     0, 0, 0,  0, 1, 0);
    tbl[2]  = mk(0, 1, 0, 0,            0,  1, 0,            0,     0, 0, 0,  0, 1, 4);
    tbl[3]  = mk(0, 1, 0, 0,            0,  1, 4,            1,     0, 0, 1,  0, 1, 8);
    tbl[4]  = mk(0, 0, 0, 0,            0,  1, 8,            2,     0, 0, 2,  0, 1, 8);
    tbl[5]  = mk(0, 0, 0, 0,            0,  1, 8,            2,     0, 0, 2,  1, 1, 8);
    tbl[6]  = mk(0, 0, 0, 0,            0,  1, 8,            2,     0, 0, 2,  2, 1, 8);
    tbl[7]  = mk(0, 1, 0, 0,            0,  1, 8,            2,     0, 0, 2,  3, 1, 12);
    tbl[8]  = mk(0, 1, 0, 0,            0,  1, 12,           3,     0, 0, 3,  3, 1, 16);
    tbl[9]  = mk(0, 0, 1, 32'h40,       0,  0, 0,            0,     0, 0, 4,  3, 1, 32'h40);
    tbl[10] = mk(0, 1, 0, 0,            0,  1, 32'h40,       16,    0, 0, 4,  3, 1, 32'h44);
    tbl[11] = mk(0, 1, 1, 32'h42,       0,  0, 0,            0,     0, 0, 5,  3, 1, 32'h40);
    tbl[12] = mk(0, 1, 0, 0,            0,  1, 32'h40,       16,    0, 1, 5,  3, 1, 32'h44);
    tbl[13] = mk(0, 1, 1, 32'h8,        0,  0, 0,            0,     0, 1, 6,  3, 1, 8);
    tbl[14] = mk(0, 1, 0, 0,            0,  1, 8,            2,     0, 1, 6,  3, 1, 12);
    tbl[15] = mk(0, 1, 0, 0,            0,  1, 12,           3,     0, 1, 7,  3, 1, 16);
    tbl[16] = mk(0, 1, 0, 0,            1,  1, 16,           4,     0, 1, 8,  3, 1, 20);
    tbl[17] = mk(0, 1, 0, 0,            1,  0, 0,            0,     1, 1, 9,  3, 0, 0);
    tbl[18] = mk(0, 1, 0, 0,            0,  0, 0,            0,     1, 1, 9,  3, 0, 0);
    tbl[19] = mk(0, 0, 0, 0,            0,  0, 0,            0,     1, 1, 9,  3, 0, 0);
    tbl[20] = mk(0, 1, 0, 0,            0,  0, 0,            0,     1, 1, 9,  3, 0, 0);
    tbl[21] = mk(0, 1, 0, 0,            0,  0, 0,            0,     1, 1, 9,  3, 0, 0);
    tbl[22] = mk(0, 1, 1, 32'h0,        0,  0, 0,            0,     1, 1, 9,  3, 1, 0);
    tbl[23] = mk(0, 1, 0, 0,            0,  1, 0,            0,     0, 1, 9,  3, 1, 4);
    tbl[24] = mk(0, 1, 1, 32'hFFFFFFFC, 0,  0, 0,            0,     0, 1, 10, 3, 1, 32'hFFFFFFFC);
    tbl[25] = mk(0, 1, 0, 0,            0,  1, 32'hFFFFFFFC, 32'hFFF, 0, 1, 10, 3, 1, 0);
    tbl[26] = mk(0, 1, 0, 0,            0,  1, 0,            0,     0, 1, 11, 3, 1, 4);
    tbl[27] = mk(0, 0, 0, 0,            0,  1, 4,            1,     0, 1, 12, 3, 1, 4);
    tbl[28] = mk(1, 0, 0, 0,            0,  0, 0,            0,     0, 1, 12, 4, 1, 0);
    tbl[29] = mk(0, 0, 0, 0,            0,  0, 0,            0,     0, 0, 0,  0, 1, 0);
    tbl[30] = mk(0, 1, 0, 0,            0,  1, 0,            0,     0, 0, 0,  0, 1, 4);
    tbl[31] = mk(0, 1, 1, 32'h20,       1,  0, 0,            0,     0, 0, 1,  0, 1, 32'h20);
    tbl[32] = mk(0, 1, 0, 0,            0,  1, 32'h20,       8,     0, 0, 1,  0, 1, 32'h24);
    tbl[33] = mk(0, 0, 0, 0,            1,  1, 32'h24,       9,     0, 0, 2,  0, 1, 32'h24);
    tbl[34] = mk(0, 1, 0, 0,            0,  0, 0,            0,     1, 0, 2,  1, 0, 0);

    // Bring registers to a known state before the directed table.
    repeat (2) @(negedge clock);

    for (int i = 0; i < N_VEC; i++) begin
      @(negedge clock);
      reset = tbl[i].rst; inst_ready = tbl[i].rdy; redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc; halt_req = tbl[i].hr;
      #1;
      check($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        check($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
        check($sformatf("v%0d_inst", i), inst, tbl[i].e_inst);
      end
      check($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, tbl[i].e_halted});
      check($sformatf("v%0d_misalign", i), {31'd0, misalign_err}, {31'd0, tbl[i].e_mis});
      check($sformatf("v%0d_fetch_count", i), fetch_count, tbl[i].e_fc);
      check($sformatf("v%0d_stall_count", i), stall_count, tbl[i].e_sc);
      if (tbl[i].c_addr) check($sformatf("v%0d_rom_addr", i), rom_addr, tbl[i].e_addr);
    end

    // Randomized phase: one reset cycle syncs the model, then free-running.
    @(negedge clock);
    reset = 1; redirect_valid = 0; halt_req = 0; inst_ready = 1;
    #1;
    model_step();
    for (int c = 0; c < N_RAND; c++) begin
      @(negedge clock);
      reset          = ($urandom_range(0, 199) == 0);
      inst_ready     = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 9) == 0);
      halt_req       = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        1:       redirect_pc = $urandom();
        default: redirect_pc = 32'($urandom_range(0, 255)) << 2;
      endcase
      #1;
      model_check();
      model_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
